// File: rtl/change_dispenser.sv
// change_dispenser: queues change codes from the vending machine and pays
// them out one 5-unit coin at a time through a req/ack hopper handshake.
// A hopper that never acks raises a sticky jam; a full queue raises ovf.
module change_dispenser #(
    parameter int DEPTH       = 4,
    parameter int GAP_CYC     = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] change,
    input  logic       coin_ack,
    input  logic       clr_err,
    output logic       coin_req,
    output logic       busy,
    output logic       jam,
    output logic       ovf,
    output logic [7:0] paid_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(ACK_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {IDLE, REQ, GAP, JAM} state_t;

    state_t        state;
    logic [1:0]    fifo_mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [1:0]    coins_left;
    logic [WW-1:0] wait_cnt;
    logic [GW-1:0] gap_cnt;

    logic empty, full, valid_code, pop, push, drop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign valid_code = (change == 2'd1) || (change == 2'd2);
    // An IDLE pop frees a slot in the same cycle, so a push into a full queue still fits.
    assign pop        = (state == IDLE) && !empty;
    assign push       = valid_code && (!full || pop);
    assign drop       = valid_code && full && !pop;
    assign busy       = (state != IDLE) || !empty;

    // Queue storage; entries are only read after being written, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= change;
    end

    // Queue pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Payout FSM: coin_req mirrors the REQ state and is registered with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            coins_left <= '0;
            wait_cnt   <= '0;
            gap_cnt    <= '0;
            coin_req   <= 1'b0;
            jam        <= 1'b0;
            paid_cnt   <= '0;
        end else begin
            // A timeout in the same cycle overrides this clear below.
            if (clr_err) jam <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        coins_left <= fifo_mem[rd_ptr[AW-1:0]];
                        wait_cnt   <= '0;
                        coin_req   <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (coin_ack) begin
                        paid_cnt   <= paid_cnt + 8'd1;
                        coins_left <= coins_left - 2'd1;
                        wait_cnt   <= '0;
                        gap_cnt    <= '0;
                        coin_req   <= 1'b0;
                        state      <= GAP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        coin_req <= 1'b0;
                        jam      <= 1'b1;
                        state    <= JAM;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        if (coins_left != 2'd0) begin
                            wait_cnt <= '0;
                            coin_req <= 1'b1;
                            state    <= REQ;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                JAM: begin
                    // Unpaid coins stay in coins_left; the GAP path retries them.
                    if (clr_err) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Overflow flag: a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         ovf <= 1'b0;
        else if (drop)    ovf <= 1'b1;
        else if (clr_err) ovf <= 1'b0;
    end
endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus randomized bursts checked
// against a coin-total model (each accepted code of 1 or 2 pays that many coins).
module tb_change_dispenser;
    localparam int DEPTH       = 4;
    localparam int GAP_CYC     = 2;
    localparam int ACK_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] change = 2'd0;
    logic       coin_ack;
    logic       clr_err = 1'b0;
    logic       coin_req, busy, jam, ovf;
    logic [7:0] paid_cnt;

    int checks = 0;
    int errors = 0;

    // hopper behaviour knobs
    bit auto_ack = 1'b0;
    bit stray    = 1'b0;
    int ack_lo   = 1;
    int ack_hi   = 1;

    // coin_req observation
    int pulses   = 0;
    int gap_viol = 0;

    change_dispenser #(.DEPTH(DEPTH), .GAP_CYC(GAP_CYC), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .change(change), .coin_ack(coin_ack), .clr_err(clr_err),
        .coin_req(coin_req), .busy(busy), .jam(jam), .ovf(ovf), .paid_cnt(paid_cnt)
    );

    always #5 clk = ~clk;

    // Hopper model: acks the N-th cycle of a request, optionally acks while idle.
    initial begin
        int age;
        int ack_at;
        coin_ack = 1'b0;
        age = 0;
        ack_at = 1;
        forever begin
            @(negedge clk);
            coin_ack = 1'b0;
            if (coin_req) begin
                age++;
                if (auto_ack && age >= ack_at) coin_ack = 1'b1;
            end else begin
                age = 0;
                ack_at = int'($urandom_range(ack_hi, ack_lo));
                if (stray && $urandom_range(3, 0) == 0) coin_ack = 1'b1;
            end
        end
    end

    // Count request pulses and the low spacing in front of each one.
    initial begin
        bit prev;
        int low_run;
        prev = 1'b0;
        low_run = 100;
        forever begin
            @(negedge clk);
            if (coin_req && !prev) begin
                pulses++;
                if (low_run < GAP_CYC) gap_viol++;
            end
            low_run = coin_req ? 0 : low_run + 1;
            prev = coin_req;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; change = 2'd0; clr_err = 1'b0; auto_ack = 1'b0; stray = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({coin_req, busy, jam, ovf, paid_cnt} !== 12'h0) begin
            errors++;
            $display("FAIL reset_hold: outs=%h expected 000", {coin_req, busy, jam, ovf, paid_cnt});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({coin_req, busy, jam, ovf, paid_cnt} !== 12'h0) begin
            errors++;
            $display("FAIL reset_release: outs=%h expected 000", {coin_req, busy, jam, ovf, paid_cnt});
        end
    endtask

    task automatic test_two_coins();
        logic [9:0] wave;
        do_reset();
        auto_ack = 1'b1; ack_lo = 2; ack_hi = 2;
        @(negedge clk) change = 2'd2;
        @(negedge clk) change = 2'd0;
        wave[0] = coin_req;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            wave[k] = coin_req;
        end
        checks++;
        if (wave !== 10'b0001100110) begin
            errors++;
            $display("FAIL two_coins_wave: coin_req trace=%b expected 0001100110", wave);
        end
        checks++;
        if (paid_cnt !== 8'd2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL two_coins_done: paid_cnt=%0d busy=%b expected 2 0", paid_cnt, busy);
        end
    endtask

    task automatic test_jam();
        logic [2:0] wave;
        int  high;
        bit  fell;
        do_reset();
        @(negedge clk) change = 2'd1;
        @(negedge clk) change = 2'd0;
        high = 0;
        fell = 1'b0;
        for (int i = 0; i < 60 && !fell; i++) begin
            @(negedge clk);
            if (coin_req) high++;
            else if (high > 0) fell = 1'b1;
        end
        checks++;
        if (high != ACK_TIMEOUT || jam !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL jam_timeout: req_cycles=%0d jam=%b busy=%b expected %0d 1 1", high, jam, busy, ACK_TIMEOUT);
        end
        // acks while jammed must not count or restart payout
        stray = 1'b1;
        repeat (6) @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        checks++;
        if (paid_cnt !== 8'd0 || jam !== 1'b1 || coin_req !== 1'b0) begin
            errors++;
            $display("FAIL jam_ignores_ack: paid_cnt=%0d jam=%b coin_req=%b expected 0 1 0", paid_cnt, jam, coin_req);
        end
        @(negedge clk);
        clr_err = 1'b1; auto_ack = 1'b1; ack_lo = 1; ack_hi = 1;
        @(negedge clk);
        clr_err = 1'b0;
        wave[0] = coin_req;
        checks++;
        if (jam !== 1'b0) begin
            errors++;
            $display("FAIL jam_clear: jam=%b expected 0", jam);
        end
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            wave[k] = coin_req;
        end
        checks++;
        if (wave !== 3'b100) begin
            errors++;
            $display("FAIL jam_retry_wave: coin_req trace=%b expected 100", wave);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (paid_cnt !== 8'd1 || jam !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL jam_retry_paid: paid_cnt=%0d jam=%b busy=%b expected 1 0 0", paid_cnt, jam, busy);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        int p0;
        do_reset();
        @(negedge clk) change = 2'd2;
        repeat (6) @(negedge clk);
        change = 2'd0;
        checks++;
        if (ovf !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: ovf=%b busy=%b expected 1 1", ovf, busy);
        end
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (jam) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ovf_jam_wait: jam=%b expected 1 within 40 cycles", jam);
        end
        // overflow and clear in the same cycle: the overflow must win
        change = 2'd1; clr_err = 1'b1; p0 = pulses;
        @(negedge clk);
        change = 2'd0; clr_err = 1'b0;
        auto_ack = 1'b1; ack_lo = 1; ack_hi = 4;
        checks++;
        if (ovf !== 1'b1 || jam !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr_race: ovf=%b jam=%b expected 1 0", ovf, jam);
        end
        repeat (3) @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b expected 0", ovf);
        end
        wait_idle(400, ok);
        checks++;
        if (!ok || paid_cnt !== 8'd10 || (pulses - p0) != 10) begin
            errors++;
            $display("FAIL ovf_drain: idle=%0d paid_cnt=%0d pulses=%0d expected 1 10 10", ok, paid_cnt, pulses - p0);
        end
    endtask

    task automatic test_ignored_codes();
        logic [1:0] code;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            code = (i < 5) ? 2'd3 : 2'd0;
            @(negedge clk);
            change = code;
            checks++;
            if ({coin_req, busy, ovf} !== 3'b000) begin
                errors++;
                $display("FAIL ignored_codes cycle %0d: coin_req/busy/ovf=%b expected 000", i, {coin_req, busy, ovf});
            end
        end
        @(negedge clk);
        change = 2'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({coin_req, busy, ovf} !== 3'b000 || paid_cnt !== 8'd0) begin
            errors++;
            $display("FAIL ignored_codes_end: coin_req/busy/ovf=%b paid_cnt=%0d expected 000 0", {coin_req, busy, ovf}, paid_cnt);
        end
    endtask

    task automatic test_reset_mid_req();
        bit ok;
        int p0;
        do_reset();
        @(negedge clk) change = 2'd2;
        @(negedge clk) change = 2'd1;
        @(negedge clk) change = 2'd0;
        ok = coin_req;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = coin_req;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mid_req_start: coin_req=%b expected 1", coin_req);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({coin_req, busy, jam, ovf, paid_cnt} !== 12'h0) begin
            errors++;
            $display("FAIL mid_req_async: outs=%h expected 000", {coin_req, busy, jam, ovf, paid_cnt});
        end
        p0 = pulses;
        @(negedge clk);
        rst = 1'b1; auto_ack = 1'b1; ack_lo = 1; ack_hi = 2;
        repeat (30) @(negedge clk);
        checks++;
        if ((pulses - p0) != 0 || busy !== 1'b0 || paid_cnt !== 8'd0) begin
            errors++;
            $display("FAIL mid_req_quiet: pulses=%0d busy=%b paid_cnt=%0d expected 0 0 0", pulses - p0, busy, paid_cnt);
        end
        @(negedge clk) change = 2'd1;
        @(negedge clk) change = 2'd0;
        wait_idle(60, ok);
        checks++;
        if (!ok || paid_cnt !== 8'd1) begin
            errors++;
            $display("FAIL mid_req_resume: idle=%0d paid_cnt=%0d expected 1 1", ok, paid_cnt);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        bit moved;
        do_reset();
        auto_ack = 1'b1; ack_lo = 1; ack_hi = 1;
        for (int i = 0; i < 127; i++) begin
            @(negedge clk) change = 2'd2;
            @(negedge clk) change = 2'd0;
            wait_idle(60, ok);
            checks++;
            if (!ok || paid_cnt !== 8'(2 * (i + 1))) begin
                errors++;
                $display("FAIL wrap_fill req %0d: idle=%0d paid_cnt=%0d expected %0d", i, ok, paid_cnt, 2 * (i + 1));
            end
        end
        @(negedge clk) change = 2'd2;
        @(negedge clk) change = 2'd0;
        moved = 1'b0;
        for (int i = 0; i < 20 && !moved; i++) begin
            @(negedge clk);
            moved = (paid_cnt !== 8'd254);
        end
        checks++;
        if (paid_cnt !== 8'd255) begin
            errors++;
            $display("FAIL wrap_255: paid_cnt=%0d expected 255", paid_cnt);
        end
        moved = 1'b0;
        for (int i = 0; i < 20 && !moved; i++) begin
            @(negedge clk);
            moved = (paid_cnt !== 8'd255);
        end
        checks++;
        if (paid_cnt !== 8'd0) begin
            errors++;
            $display("FAIL wrap_0: paid_cnt=%0d expected 0", paid_cnt);
        end
        wait_idle(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wrap_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_random();
        int exp_paid;
        int n_valid;
        int len;
        logic [1:0] code;
        bit ok;
        do_reset();
        auto_ack = 1'b1; ack_lo = 1; ack_hi = 5; stray = 1'b1;
        exp_paid = 0;
        for (int b = 0; b < 40; b++) begin
            len = int'($urandom_range(6, 1));
            n_valid = 0;
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                code = 2'($urandom_range(3, 0));
                // at most five valid codes per burst keeps the queue from overflowing
                if (code == 2'd1 || code == 2'd2) begin
                    if (n_valid == 5) code = 2'd0;
                    else begin
                        n_valid++;
                        exp_paid += int'(code);
                    end
                end
                change = code;
            end
            @(negedge clk) change = 2'd0;
            wait_idle(400, ok);
            checks++;
            if (!ok || paid_cnt !== 8'(exp_paid)) begin
                errors++;
                $display("FAIL random_paid burst %0d: idle=%0d paid_cnt=%0d expected %0d", b, ok, paid_cnt, exp_paid % 256);
            end
            checks++;
            if ({jam, ovf} !== 2'b00) begin
                errors++;
                $display("FAIL random_flags burst %0d: jam/ovf=%b expected 00", b, {jam, ovf});
            end
        end
        stray = 1'b0;
        checks++;
        if (gap_viol != 0) begin
            errors++;
            $display("FAIL gap_spacing: short gaps=%0d expected 0", gap_viol);
        end
    endtask

    initial begin
        test_reset();
        test_two_coins();
        test_jam();
        test_overflow();
        test_ignored_codes();
        test_reset_mid_req();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
